// File: rtl/div_sequencer.sv
// Multi-cycle 32-bit integer divider for DIV/DIVU/REM/REMU: restoring radix-2, one bit per cycle.
// Divide-by-zero and signed overflow bypass the iteration and finish one cycle after the start.
module div_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        stall_EX,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StDone
  } state_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q;
  logic [31:0] quot_q;      // dividend bits shift out of the top, quotient bits shift in below
  logic [31:0] rem_q;
  logic [31:0] divisor_q;
  logic        rem_sel_q;   // 1: REM/REMU, 0: DIV/DIVU
  logic        neg_quot_q;
  logic        neg_rem_q;
  logic [31:0] result_q;

  logic        accept;
  logic        signed_op;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic        div_zero;
  logic        overflow;
  logic [32:0] rem_shift;
  logic        rem_ge;
  logic [31:0] rem_sub;
  logic [31:0] rem_next;
  logic [31:0] quot_next;
  logic [31:0] quot_fix;
  logic [31:0] rem_fix;
  logic [31:0] res_fix;

  // Operand preparation for a new request
  always_comb begin
    accept    = (state_q == StIdle) && start;
    signed_op = ~op[0];
    a_neg     = signed_op & a[31];
    b_neg     = signed_op & b[31];
    a_mag     = a_neg ? (~a + 32'd1) : a;
    b_mag     = b_neg ? (~b + 32'd1) : b;
    div_zero  = (b == 32'd0);
    overflow  = signed_op && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
  end

  // One restoring iteration
  always_comb begin
    rem_shift = {rem_q, quot_q[31]};
    rem_ge    = (rem_shift >= {1'b0, divisor_q});
    // The true difference is below 2^32 whenever it is used, so 32 bits suffice
    rem_sub   = rem_shift[31:0] - divisor_q;
    rem_next  = rem_ge ? rem_sub : rem_shift[31:0];
    quot_next = {quot_q[30:0], rem_ge};
  end

  // Sign fix-up and result select
  always_comb begin
    quot_fix = neg_quot_q ? (~quot_q + 32'd1) : quot_q;
    rem_fix  = neg_rem_q ? (~rem_q + 32'd1) : rem_q;
    res_fix  = rem_sel_q ? rem_fix : quot_fix;
  end

  always_comb begin
    state_d  = state_q;
    stall_EX = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (state_q)
      StIdle: begin
        stall_EX = start;
        if (start) begin
          state_d = (div_zero || overflow) ? StDone : StCalc;
        end
      end
      StCalc: begin
        stall_EX = 1'b1;
        busy     = 1'b1;
        if (cnt_q == 5'd31) begin
          state_d = StDone;
        end
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Present the fixed-up value in the done cycle itself, then hold it
  assign result = (state_q == StDone) ? res_fix : result_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= 5'd0;
      quot_q     <= 32'd0;
      rem_q      <= 32'd0;
      divisor_q  <= 32'd0;
      rem_sel_q  <= 1'b0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      result_q   <= 32'd0;
    end else begin
      if (accept) begin
        cnt_q     <= 5'd0;
        rem_sel_q <= op[1];
        divisor_q <= b_mag;
        if (div_zero) begin
          quot_q     <= 32'hFFFF_FFFF;
          rem_q      <= a;
          neg_quot_q <= 1'b0;
          neg_rem_q  <= 1'b0;
        end else if (overflow) begin
          quot_q     <= 32'h8000_0000;
          rem_q      <= 32'd0;
          neg_quot_q <= 1'b0;
          neg_rem_q  <= 1'b0;
        end else begin
          quot_q     <= a_mag;
          rem_q      <= 32'd0;
          neg_quot_q <= a_neg ^ b_neg;
          neg_rem_q  <= a_neg;
        end
      end else if (state_q == StCalc) begin
        quot_q <= quot_next;
        rem_q  <= rem_next;
        cnt_q  <= cnt_q + 5'd1;
      end else if (state_q == StDone) begin
        result_q <= res_fix;
      end
    end
  end

endmodule

// File: tb/tb_div_sequencer.sv
// Directed-vector bench for div_sequencer: results, latency, stall window, ignored starts, reset.
module tb_div_sequencer;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        stall_EX;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int n_vec;
  int n_bad;

  localparam logic [1:0] OpDiv  = 2'b00;
  localparam logic [1:0] OpDivu = 2'b01;
  localparam logic [1:0] OpRem  = 2'b10;
  localparam logic [1:0] OpRemu = 2'b11;

  div_sequencer dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .stall_EX (stall_EX),
    .busy     (busy),
    .done     (done),
    .result   (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issue one request and follow it to completion. inject > 0 pulses a foreign start
  // that many cycles after the accept; the done cycle always carries a start that must be ignored.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] exp, input int exp_lat,
                        input int inject);
    int  stalls;
    int  lat;
    bit  seen;
    @(negedge clk);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    #1;
    check({tag, " stall@N"}, 32'(stall_EX), 32'd1);
    stalls = 0;
    lat    = 0;
    seen   = 1'b0;
    for (int c = 1; c <= 40 && !seen; c++) begin
      @(negedge clk);
      start = (c == inject);
      if (c == inject) begin
        op = OpRem;
        a  = 32'h0000_0055;
        b  = 32'h0000_0001;
      end
      #1;
      if (done) begin
        seen = 1'b1;
        lat  = c;
      end else if (stall_EX) begin
        stalls++;
      end
    end
    check({tag, " done seen"}, 32'(seen), 32'd1);
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " result"}, result, exp);
    check({tag, " busy@done"}, 32'(busy), 32'd0);
    check({tag, " stall cycles"}, 32'(stalls), 32'(exp_lat - 1));
    // start during DONE must not stall and must not be accepted
    start = 1'b1;
    op    = OpDivu;
    a     = 32'h0000_0064;
    b     = 32'h0000_0005;
    #1;
    check({tag, " stall@done"}, 32'(stall_EX), 32'd0);
    @(negedge clk);
    start = 1'b0;
    #1;
    check({tag, " idle after"}, {29'd0, busy, done, stall_EX}, 32'd0);
    check({tag, " held"}, result, exp);
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    rst   = 1'b1;
    start = 1'b0;
    op    = OpDiv;
    a     = 32'd0;
    b     = 32'd0;
    #1;
    check("reset outputs", {29'd0, busy, done, stall_EX}, 32'd0);
    check("reset result", result, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    run_op("div 100/7",       OpDiv,  32'd100,        32'd7,          32'h0000_000E, 33, 0);
    run_op("rem -7/2",        OpRem,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF, 33, 0);
    run_op("div -7/2",        OpDiv,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD, 33, 0);
    run_op("div -100/7",      OpDiv,  32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFF2, 33, 0);
    run_op("rem 100/-7",      OpRem,  32'd100,        32'hFFFF_FFF9,  32'h0000_0002, 33, 0);
    run_op("divu x/0",        OpDivu, 32'h1234_5678,  32'd0,          32'hFFFF_FFFF, 1,  0);
    run_op("remu x/0",        OpRemu, 32'h1234_5678,  32'd0,          32'h1234_5678, 1,  0);
    run_op("rem -5/0",        OpRem,  32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFB, 1,  0);
    run_op("div ovf",         OpDiv,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000, 1,  0);
    run_op("rem ovf",         OpRem,  32'h8000_0000,  32'hFFFF_FFFF,  32'h0000_0000, 1,  0);
    run_op("divu no-ovf",     OpDivu, 32'h8000_0000,  32'hFFFF_FFFF,  32'h0000_0000, 33, 0);
    run_op("divu inject",     OpDivu, 32'hFFFF_FFFF,  32'h0000_0010,  32'h0FFF_FFFF, 33, 10);

    // Reset in the middle of a calculation
    @(negedge clk);
    start = 1'b1;
    op    = OpDivu;
    a     = 32'd1000;
    b     = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    #1;
    check("busy before rst", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check("rst mid-calc flags", {29'd0, busy, done, stall_EX}, 32'd0);
    check("rst mid-calc result", result, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_op("divu 9/3 post-rst", OpDivu, 32'd9, 32'd3, 32'h0000_0003, 33, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
